cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Complete stage directly downstream of the functional units.
//  - Each cycle, picks up to NUM_CDB results from FUs whose "prepared" is high, using round-robin priority.
//  - Registers the picks onto the CDB (PRF writeback, RS wakeup) and onto the ROB completion ports.
//  - Returns per-FU avail: a multi-cycle FU holds its result until it sees avail.
// PARAMETERS
//  NUM_FU   5   requesters, flattened {load, mult, alu}; index 0 = ALU0
//  NUM_CDB  2   results broadcast per cycle (1..NUM_FU)
//  PRN_W    6   physical register number width
//  ROBN_W   5   ROB index width
//  DATA_W   32  result width
// PORTS
//  clock            in   1               system clock, rising edge
//  reset            in   1               asynchronous, active-high
//  squash           in   1               branch mispredict flush
//  fu_prepared      in   NUM_FU          FU i holds a valid result
//  fu_robn          in   NUM_FU*ROBN_W   ROB index of FU i result
//  fu_dest_prn      in   NUM_FU*PRN_W    dest PRN of FU i; 0 = no register write
//  fu_result        in   NUM_FU*DATA_W   result value; branch target when fu_take_branch=1
//  fu_take_branch   in   NUM_FU          resolved taken (ALU only, others tie 0)
//  fu_avail         out  NUM_FU          combinational; FU i may advance this cycle
//  cdb_valid        out  NUM_CDB         registered CDB slot valid
//  cdb_prn          out  NUM_CDB*PRN_W   registered dest PRN
//  cdb_value        out  NUM_CDB*DATA_W  registered value
//  rob_valid        out  NUM_CDB         registered completion valid
//  rob_robn         out  NUM_CDB*ROBN_W  registered ROB index
//  rob_taken        out  NUM_CDB         registered branch taken
//  rob_target       out  NUM_CDB*DATA_W  registered target (= result if taken, else 0)
// BEHAVIOUR
//  Reset:
//  - All registered outputs are 0.
//  - Round-robin pointer ptr = 0.
//  - fu_avail = ~fu_prepared (no grants).
//  Arbitration (combinational, same cycle):
//  - Scan indices ptr, ptr+1, ... with wrap modulo NUM_FU.
//  - Grant the first NUM_CDB indices whose fu_prepared is high.
//  - Slot k carries the k-th grant in scan order; unused slots are invalid.
//  - fu_avail[i] = grant[i] | ~fu_prepared[i].
//    An idle FU is never stalled; a prepared, ungranted FU sees avail=0 and must hold its outputs.
//  Pointer update (edge):
//  - If >=1 grant: ptr <= (last granted index + 1) mod NUM_FU.
//  - If no grant: ptr is unchanged.
//  Output registers (1-cycle latency, grant at cycle t -> visible at t+1):
//  - rob_valid[k] <= slot k granted.
//  - cdb_valid[k] <= slot k granted && dest_prn != 0 (x0 results complete in ROB but are never broadcast).
//  - rob_target[k] <= take_branch ? result : 0.
//  - Payload fields of an invalid slot are 0.
//  Squash (sampled at edge, takes priority over everything):
//  - Grants forced to 0 and fu_avail forced all-1, so in-flight FU results are dropped.
//  - At the next edge: all valids <= 0 and ptr <= 0.
//  - Outputs registered before the squash edge remain visible for their one cycle.
//  Boundaries:
//  - More requesters than NUM_CDB: losers stall with avail=0. A continuously prepared FU is granted within ceil(NUM_FU/NUM_CDB) cycles.
//  - Wrap: ptr = NUM_FU-1 scans NUM_FU-1, 0, 1, ...
//  - No requests: all valids 0 next cycle, ptr held.
//  - Reset asserted mid-operation clears the outputs immediately (async), independent of clock.
// TESTING
//  1. Reset held, all prepared=1 -> all outputs 0, fu_avail=0; release -> slots 0,1 = FU0,FU1 next cycle; ptr=2.
//  2. Only FU3 prepared, dest_prn=7, result=0x55 -> cycle+1: cdb_valid=01, cdb_prn[0]=7, cdb_value[0]=0x55, rob_valid=01.
//  3. All 5 prepared for 3 cycles, NUM_CDB=2 -> grants {0,1}, {2,3}, {4,0}; ptr = 2, 4, 1; ungranted avail=0.
//  4. FU0 prepared, dest_prn=0, take_branch=1, result=0x1000 -> rob_valid[0]=1, rob_taken=1, rob_target=0x1000, cdb_valid=0.
//  5. squash with FU1, FU2 prepared -> fu_avail=11111; next cycle all valids 0, ptr=0.
//  6. Assert reset between edges with valids set -> outputs clear before next edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of up to NUM_CDB finished FU results,
// registered onto the CDB broadcast and ROB completion ports, with per-FU backpressure.
module cdb_arbiter #(
  parameter int NUM_FU  = 5,
  parameter int NUM_CDB = 2,
  parameter int PRN_W   = 6,
  parameter int ROBN_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_prepared,
  input  logic [NUM_FU*ROBN_W-1:0]    fu_robn,
  input  logic [NUM_FU*PRN_W-1:0]     fu_dest_prn,
  input  logic [NUM_FU*DATA_W-1:0]    fu_result,
  input  logic [NUM_FU-1:0]           fu_take_branch,
  output logic [NUM_FU-1:0]           fu_avail,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*PRN_W-1:0]    cdb_prn,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic [NUM_CDB-1:0]          rob_valid,
  output logic [NUM_CDB*ROBN_W-1:0]   rob_robn,
  output logic [NUM_CDB-1:0]          rob_taken,
  output logic [NUM_CDB*DATA_W-1:0]   rob_target
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]          ptr;
  logic [PTR_W-1:0]          ptr_next;
  logic [NUM_FU-1:0]         grant;
  logic [NUM_CDB-1:0]        slot_used;
  logic [PTR_W-1:0]          slot_idx [NUM_CDB];

  logic [NUM_CDB-1:0]        cdb_valid_d;
  logic [NUM_CDB*PRN_W-1:0]  cdb_prn_d;
  logic [NUM_CDB*DATA_W-1:0] cdb_value_d;
  logic [NUM_CDB-1:0]        rob_valid_d;
  logic [NUM_CDB*ROBN_W-1:0] rob_robn_d;
  logic [NUM_CDB-1:0]        rob_taken_d;
  logic [NUM_CDB*DATA_W-1:0] rob_target_d;

  // Each slot claims the first still-pending FU in scan order starting at ptr.
  always_comb begin : arbitrate
    logic [NUM_FU-1:0] pending;
    logic [PTR_W:0]    pos;
    logic [PTR_W-1:0]  idx;
    logic              found;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    grant     = '0;
    slot_used = '0;
    ptr_next  = ptr;
    pos       = '0;
    idx       = '0;
    found     = 1'b0;
    pending   = (squash || reset) ? '0 : fu_prepared;
    for (int s = 0; s < NUM_CDB; s++) begin
      slot_idx[s] = '0;
      found       = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
        pos = {1'b0, ptr} + (PTR_W+1)'(k);
        if (pos >= (PTR_W+1)'(NUM_FU)) pos = pos - (PTR_W+1)'(NUM_FU);
        idx = pos[PTR_W-1:0];
        if (!found && pending[idx]) begin
          found        = 1'b1;
          pending[idx] = 1'b0;
          grant[idx]   = 1'b1;
          slot_used[s] = 1'b1;
          slot_idx[s]  = idx;
          ptr_next     = (idx == PTR_W'(NUM_FU-1)) ? '0 : idx + 1'b1;
        end
      end
    end
    if (squash) ptr_next = '0;
  end

  // Squash releases every FU so in-flight results are dropped rather than stalled.
  assign fu_avail = squash ? '1 : (grant | ~fu_prepared);

  always_comb begin : payload
    logic [PTR_W-1:0]  i;
    logic [PRN_W-1:0]  prn;
    logic [DATA_W-1:0] res;
    logic              taken;
    i            = '0;
    prn          = '0;
    res          = '0;
    taken        = 1'b0;
    cdb_valid_d  = '0;
    cdb_prn_d    = '0;
    cdb_value_d  = '0;
    rob_valid_d  = '0;
    rob_robn_d   = '0;
    rob_taken_d  = '0;
    rob_target_d = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      if (slot_used[s]) begin
        i     = slot_idx[s];
        prn   = fu_dest_prn[i*PRN_W +: PRN_W];
        res   = fu_result[i*DATA_W +: DATA_W];
        taken = fu_take_branch[i];
        rob_valid_d[s]                     = 1'b1;
        rob_robn_d[s*ROBN_W +: ROBN_W]     = fu_robn[i*ROBN_W +: ROBN_W];
        rob_taken_d[s]                     = taken;
        rob_target_d[s*DATA_W +: DATA_W]   = taken ? res : '0;
        // Writes to x0 complete in the ROB but never reach the broadcast bus.
        if (prn != '0) begin
          cdb_valid_d[s]                   = 1'b1;
          cdb_prn_d[s*PRN_W +: PRN_W]      = prn;
          cdb_value_d[s*DATA_W +: DATA_W]  = res;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      cdb_valid  <= '0;
      cdb_prn    <= '0;
      cdb_value  <= '0;
      rob_valid  <= '0;
      rob_robn   <= '0;
      rob_taken  <= '0;
      rob_target <= '0;
    end else begin
      ptr        <= ptr_next;
      cdb_valid  <= cdb_valid_d;
      cdb_prn    <= cdb_prn_d;
      cdb_value  <= cdb_value_d;
      rob_valid  <= rob_valid_d;
      rob_robn   <= rob_robn_d;
      rob_taken  <= rob_taken_d;
      rob_target <= rob_target_d;
    end
  end

endmodule
